// File: rtl/write_handler_tmr_if.sv
// Write-handler bus: producer request, synchronised read pointer, voted
// address/pointer/full outputs and TMR status.
interface write_handler_tmr_if #(
  parameter int unsigned ADDRESS_SIZE = 4
);
  logic                    write_enable;
  logic [ADDRESS_SIZE:0]   synch_rgpointer;
  logic [ADDRESS_SIZE-1:0] write_address;
  logic [ADDRESS_SIZE:0]   write_pointer;
  logic                    write_full;
  logic                    tmr_error;
  logic                    tmr_error_sticky;

  modport master (
    output write_enable, synch_rgpointer,
    input  write_address, write_pointer, write_full, tmr_error, tmr_error_sticky
  );

  modport slave (
    input  write_enable, synch_rgpointer,
    output write_address, write_pointer, write_full, tmr_error, tmr_error_sticky
  );
endinterface

// File: rtl/write_handler_tmr.sv
// Async-FIFO write pointer / full-flag handler with triple modular redundancy.
// Optional macro TMR_SCRUB_EN: replicas advance from the voted state, so a
// single upset is overwritten by the majority at the next edge.
module write_handler_tmr #(
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input logic               write_clock,
  input logic               reset,
  write_handler_tmr_if.slave bus
);
  localparam int unsigned A  = ADDRESS_SIZE;
  localparam int unsigned PW = ADDRESS_SIZE + 1;

  logic [PW-1:0] w_bin  [3];
  logic [PW-1:0] w_gray [3];
  logic [2:0]    w_full;

  logic [A-1:0]  w_vaddr;
  logic [PW-1:0] w_vgray;
  logic          w_vfull;
  logic          w_inc;
  logic [PW-1:0] w_full_cmp;
  logic          w_mm;
  logic          r_tmr_error;
  logic          r_tmr_error_sticky;

  // Bitwise 2-of-3 majority voters
  assign w_vaddr = (w_bin[0][A-1:0] & w_bin[1][A-1:0]) |
                   (w_bin[0][A-1:0] & w_bin[2][A-1:0]) |
                   (w_bin[1][A-1:0] & w_bin[2][A-1:0]);
  assign w_vgray = (w_gray[0] & w_gray[1]) | (w_gray[0] & w_gray[2]) |
                   (w_gray[1] & w_gray[2]);
  assign w_vfull = (w_full[0] & w_full[1]) | (w_full[0] & w_full[2]) |
                   (w_full[1] & w_full[2]);

`ifdef TMR_SCRUB_EN
  logic [PW-1:0] w_vbin;
  assign w_vbin = (w_bin[0] & w_bin[1]) | (w_bin[0] & w_bin[2]) |
                  (w_bin[1] & w_bin[2]);
`endif

  // Writes are gated by the registered, voted full flag
  assign w_inc      = bus.write_enable & ~w_vfull;
  // Full when write pointer equals read pointer with the two MSBs inverted
  assign w_full_cmp = {~bus.synch_rgpointer[A:A-1], bus.synch_rgpointer[A-2:0]};

  for (genvar i = 0; i < 3; i++) begin : g_rep
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_wfull;
    logic [PW-1:0] w_src;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic          w_fnext;

`ifdef TMR_SCRUB_EN
    assign w_src = w_vbin;
`else
    assign w_src = r_wbin;
`endif
    assign w_bnext = w_src + PW'(w_inc);
    assign w_gnext = (w_bnext >> 1) ^ w_bnext;
    assign w_fnext = (w_gnext == w_full_cmp);

    // Replica state register
    always_ff @(posedge write_clock or negedge reset) begin
      if (!reset) begin
        r_wbin  <= '0;
        r_wgray <= '0;
        r_wfull <= 1'b0;
      end else begin
        r_wbin  <= w_bnext;
        r_wgray <= w_gnext;
        r_wfull <= w_fnext;
      end
    end

    assign w_bin[i]  = r_wbin;
    assign w_gray[i] = r_wgray;
    assign w_full[i] = r_wfull;
  end

  // Any replica disagreement on any state bit
  assign w_mm = (w_bin[0]  != w_bin[1])  | (w_bin[1]  != w_bin[2])  |
                (w_gray[0] != w_gray[1]) | (w_gray[1] != w_gray[2]) |
                (w_full[0] != w_full[1]) | (w_full[1] != w_full[2]);

  // Registered mismatch flag and its sticky copy
  always_ff @(posedge write_clock or negedge reset) begin
    if (!reset) begin
      r_tmr_error        <= 1'b0;
      r_tmr_error_sticky <= 1'b0;
    end else begin
      r_tmr_error        <= w_mm;
      r_tmr_error_sticky <= r_tmr_error_sticky | w_mm;
    end
  end

  assign bus.write_address    = w_vaddr;
  assign bus.write_pointer    = w_vgray;
  assign bus.write_full       = w_vfull;
  assign bus.tmr_error        = r_tmr_error;
  assign bus.tmr_error_sticky = r_tmr_error_sticky;
endmodule

// File: tb/tb_write_handler_tmr.sv
// Directed self-checking bench for write_handler_tmr (ADDRESS_SIZE = 4).
module tb_write_handler_tmr;
  logic write_clock;
  logic reset;
  int   checks;
  int   errors;

  write_handler_tmr_if #(.ADDRESS_SIZE(4)) bus ();

  write_handler_tmr #(.ADDRESS_SIZE(4)) dut (
    .write_clock (write_clock),
    .reset       (reset),
    .bus         (bus)
  );

  initial begin
    write_clock = 1'b0;
    forever #5 write_clock = ~write_clock;
  end

  task automatic step();
    @(posedge write_clock);
    @(negedge write_clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.write_enable = 1'b0;
    bus.synch_rgpointer = 5'b00000;
    @(negedge write_clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.write_address !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.write_address); end
    if (bus.write_pointer !== 5'b00000) begin errors++; $display("FAIL reset_ptr: got %b expected 00000", bus.write_pointer); end
    if (bus.write_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.write_full); end
    if (bus.tmr_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.tmr_error); end
    if (bus.tmr_error_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", bus.tmr_error_sticky); end
    // three writes, then asynchronous reset mid-cycle
    bus.write_enable = 1'b1;
    repeat (3) step();
    checks += 2;
    if (bus.write_address !== 4'd3) begin errors++; $display("FAIL pre_reset_addr: got %0h expected 3", bus.write_address); end
    if (bus.write_pointer !== 5'b00010) begin errors++; $display("FAIL pre_reset_ptr: got %b expected 00010", bus.write_pointer); end
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (bus.write_address !== 4'd0) begin errors++; $display("FAIL async_reset_addr: got %0h expected 0", bus.write_address); end
    if (bus.write_pointer !== 5'b00000) begin errors++; $display("FAIL async_reset_ptr: got %b expected 00000", bus.write_pointer); end
    if (bus.write_full !== 1'b0) begin errors++; $display("FAIL async_reset_full: got %b expected 0", bus.write_full); end
    bus.write_enable = 1'b0;
    @(negedge write_clock);
    reset = 1'b1;
    bus.write_enable = 1'b1;
    step();
    bus.write_enable = 1'b0;
    checks += 2;
    if (bus.write_address !== 4'd1) begin errors++; $display("FAIL first_write_addr: got %0h expected 1", bus.write_address); end
    if (bus.write_pointer !== 5'b00001) begin errors++; $display("FAIL first_write_ptr: got %b expected 00001", bus.write_pointer); end
  endtask

  task automatic test_fill();
    do_reset();
    bus.write_enable = 1'b1;
    repeat (15) step();
    checks += 2;
    if (bus.write_full !== 1'b0) begin errors++; $display("FAIL fill15_full: got %b expected 0", bus.write_full); end
    if (bus.write_pointer !== 5'b01000) begin errors++; $display("FAIL fill15_ptr: got %b expected 01000", bus.write_pointer); end
    step();
    checks += 3;
    if (bus.write_full !== 1'b1) begin errors++; $display("FAIL fill16_full: got %b expected 1", bus.write_full); end
    if (bus.write_pointer !== 5'b11000) begin errors++; $display("FAIL fill16_ptr: got %b expected 11000", bus.write_pointer); end
    if (bus.write_address !== 4'd0) begin errors++; $display("FAIL fill16_addr: got %0h expected 0", bus.write_address); end
  endtask

  task automatic test_write_while_full();
    for (int i = 0; i < 4; i++) begin
      step();
      checks += 3;
      if (bus.write_pointer !== 5'b11000) begin errors++; $display("FAIL full_hold_ptr[%0d]: got %b expected 11000", i, bus.write_pointer); end
      if (bus.write_full !== 1'b1) begin errors++; $display("FAIL full_hold_full[%0d]: got %b expected 1", i, bus.write_full); end
      if (bus.write_address !== 4'd0) begin errors++; $display("FAIL full_hold_addr[%0d]: got %0h expected 0", i, bus.write_address); end
    end
  endtask

  task automatic test_full_release();
    // write_enable still 1: the release cycle's write is blocked
    bus.synch_rgpointer = 5'b00001;
    step();
    checks += 2;
    if (bus.write_full !== 1'b0) begin errors++; $display("FAIL release_full: got %b expected 0", bus.write_full); end
    if (bus.write_pointer !== 5'b11000) begin errors++; $display("FAIL release_ptr: got %b expected 11000", bus.write_pointer); end
    step();
    bus.write_enable = 1'b0;
    checks += 3;
    if (bus.write_pointer !== 5'b11001) begin errors++; $display("FAIL refill_ptr: got %b expected 11001", bus.write_pointer); end
    if (bus.write_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b expected 1", bus.write_full); end
    if (bus.write_address !== 4'd1) begin errors++; $display("FAIL refill_addr: got %0h expected 1", bus.write_address); end
  endtask

  task automatic test_wrap();
    logic [4:0] b;
    do_reset();
    bus.write_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      b = 5'(i);
      bus.synch_rgpointer = b ^ (b >> 1);
      step();
      checks++;
      if (bus.write_full !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d]: got %b expected 0", i, bus.write_full); end
      if (i == 30) begin
        checks++;
        if (bus.write_pointer !== 5'b10000) begin errors++; $display("FAIL wrap31_ptr: got %b expected 10000", bus.write_pointer); end
      end
    end
    bus.write_enable = 1'b0;
    checks += 2;
    if (bus.write_pointer !== 5'b00000) begin errors++; $display("FAIL wrap32_ptr: got %b expected 00000", bus.write_pointer); end
    if (bus.write_address !== 4'd0) begin errors++; $display("FAIL wrap32_addr: got %0h expected 0", bus.write_address); end
  endtask

  task automatic test_upset();
    do_reset();
    bus.write_enable = 1'b1;
    repeat (5) step();
    bus.write_enable = 1'b0;
    checks++;
    if (bus.tmr_error_sticky !== 1'b0) begin errors++; $display("FAIL upset_pre_sticky: got %b expected 0", bus.tmr_error_sticky); end
    // flip replica 2 wbin[0]: 5 -> 4
    force dut.g_rep[2].r_wbin = 5'b00100;
    release dut.g_rep[2].r_wbin;
    step();
    checks += 5;
    if (bus.write_address !== 4'd5) begin errors++; $display("FAIL upset_addr: got %0h expected 5", bus.write_address); end
    if (bus.write_pointer !== 5'b00111) begin errors++; $display("FAIL upset_ptr: got %b expected 00111", bus.write_pointer); end
    if (bus.write_full !== 1'b0) begin errors++; $display("FAIL upset_full: got %b expected 0", bus.write_full); end
    if (bus.tmr_error !== 1'b1) begin errors++; $display("FAIL upset_err: got %b expected 1", bus.tmr_error); end
    if (bus.tmr_error_sticky !== 1'b1) begin errors++; $display("FAIL upset_sticky: got %b expected 1", bus.tmr_error_sticky); end
    bus.write_enable = 1'b1;
    step();
    bus.write_enable = 1'b0;
    checks += 3;
`ifdef TMR_SCRUB_EN
    if (bus.tmr_error !== 1'b0) begin errors++; $display("FAIL upset_err_next: got %b expected 0", bus.tmr_error); end
`else
    if (bus.tmr_error !== 1'b1) begin errors++; $display("FAIL upset_err_next: got %b expected 1", bus.tmr_error); end
`endif
    if (bus.write_address !== 4'd6) begin errors++; $display("FAIL upset_write_addr: got %0h expected 6", bus.write_address); end
    if (bus.write_pointer !== 5'b00101) begin errors++; $display("FAIL upset_write_ptr: got %b expected 00101", bus.write_pointer); end
    step();
    checks += 2;
`ifdef TMR_SCRUB_EN
    if (bus.tmr_error !== 1'b0) begin errors++; $display("FAIL upset_err_late: got %b expected 0", bus.tmr_error); end
`else
    if (bus.tmr_error !== 1'b1) begin errors++; $display("FAIL upset_err_late: got %b expected 1", bus.tmr_error); end
`endif
    if (bus.tmr_error_sticky !== 1'b1) begin errors++; $display("FAIL upset_sticky_late: got %b expected 1", bus.tmr_error_sticky); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.write_enable = 1'b0;
    bus.synch_rgpointer = 5'b00000;
    test_reset();
    test_fill();
    test_write_while_full();
    test_full_release();
    test_wrap();
    test_upset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_handler_tmr.md
Name: write_handler_tmr

Overview:
- Write-side pointer/full-flag handler for the asynchronous FIFO, hardened with triple modular redundancy.
- Counterpart of the TMR read handler: runs in the write clock domain and produces the write address for the dual-port RAM.
- Produces the Gray write pointer sent to the read-domain synchroniser, and the full flag.
- Three identical pointer replicas feed bitwise majority voters; a mismatch detector flags upsets.

Parameters:
- ADDRESS_SIZE, 4, RAM address width; FIFO depth = 2^ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.

Ports:
- write_clock  input  1  write-domain clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_enable  input  1  write request from producer.
- synch_rgpointer  input  ADDRESS_SIZE+1  Gray read pointer, already 2-flop synchronised into write_clock.
- write_address  output  ADDRESS_SIZE  voted binary write address to RAM.
- write_pointer  output  ADDRESS_SIZE+1  voted Gray write pointer to read domain.
- write_full  output  1  voted full flag.
- tmr_error  output  1  registered; 1 when any replica disagreed last cycle.
- tmr_error_sticky  output  1  set by tmr_error, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every replica: wbin=0, wgray=0, wfull=0.
  - Outputs: write_address=0, write_pointer=0, write_full=0, tmr_error=0, tmr_error_sticky=0.
  - Deassertion is taken at the next rising edge.
- Replica state: wbin[A:0] binary, wgray[A:0] Gray, wfull, with A=ADDRESS_SIZE. All registered on write_clock.
- Voting: bitwise 2-of-3 majority, combinational, on wbin, wgray and wfull.
  - write_address = voted wbin[A-1:0].
  - write_pointer = voted wgray.
  - write_full = voted wfull.
- Per-replica next state, with S = that replica's source state:
  - inc = write_enable & ~write_full (gated by the VOTED full flag).
  - bnext = S.wbin + inc, modulo 2^(A+1). Wraps from all-ones to 0.
  - gnext = (bnext>>1) ^ bnext.
  - fnext = (gnext == {~synch_rgpointer[A:A-1], synch_rgpointer[A-2:0]}).
  - wbin<=bnext, wgray<=gnext, wfull<=fnext.
- Latency:
  - Pointer advances at the edge sampling write_enable=1.
  - write_address shows the next RAM slot immediately after that edge.
  - write_full asserts at the same edge the pointer reaches depth-ahead.
- Write while full: ignored. Pointer and address hold; full stays 1. The RAM write strobe (owned by the FIFO top) is write_enable & ~write_full.
- Full release: when synch_rgpointer advances, write_full falls at the next write_clock edge. Simultaneous write_enable in that cycle is still blocked, because gating uses the registered full.
- Simultaneous read-pointer change and write when not full: the write is accepted, and full is evaluated against the new pointer and new synch_rgpointer.
- Mismatch detect: mm = any bit of {wbin,wgray,wfull} differs among the three replicas.
  - tmr_error <= mm.
  - tmr_error_sticky <= tmr_error_sticky | mm.
- Voted outputs are correct under any single-replica corruption.

Optional Feature:
- Macro TMR_SCRUB_EN.
- Defined:
  - S = voted state for all replicas.
  - A corrupted replica is rewritten with the majority value at the next edge.
  - tmr_error pulses for exactly one cycle per single upset.
- Undefined:
  - S = the replica's own state; replicas are fully independent.
  - A corrupted replica stays wrong; outputs stay correct through voting.
  - tmr_error stays 1 until reset.

Test Plan:
- Reset with reset=0 mid-stream (after 3 writes) -> all outputs 0 asynchronously; after release, first write gives write_address=1, write_pointer=5'b00001.
- synch_rgpointer=0, write_enable=1 for 16 cycles -> after 16th edge write_full=1, write_pointer=5'b11000, write_address=0.
- Continue write_enable=1 for 4 more cycles while full -> write_pointer stays 5'b11000, write_full stays 1.
- From full, set synch_rgpointer=5'b00001 -> write_full=0 one edge later; one more write -> write_pointer=5'b11001, write_full=1.
- Reader tracking writer, 32 writes total -> write_pointer wraps 5'b10000 -> 5'b00000, write_full never asserts.
- Force replica 2 wbin[0] flipped for one cycle -> voted outputs unchanged, tmr_error_sticky=1.
  - With TMR_SCRUB_EN: tmr_error high exactly 1 cycle.
  - Without TMR_SCRUB_EN: tmr_error stays 1.
